// File: rtl/tim1_pkg.sv
// Shared definitions for the TIM1 time-base: CR1 bit positions, CMS encodings
// and reset constants.
package tim1_pkg;

    localparam int unsigned CR1_CEN     = 0;
    localparam int unsigned CR1_UDIS    = 1;
    localparam int unsigned CR1_URS     = 2;
    localparam int unsigned CR1_OPM     = 3;
    localparam int unsigned CR1_DIR     = 4;
    localparam int unsigned CR1_CMS_LSB = 5;
    localparam int unsigned CR1_CMS_MSB = 6;
    localparam int unsigned CR1_ARPE    = 7;

    typedef enum logic [1:0] {
        CMS_EDGE    = 2'b00,
        CMS_CENTER1 = 2'b01,
        CMS_CENTER2 = 2'b10,
        CMS_CENTER3 = 2'b11
    } cms_t;

    localparam logic RST_DIR      = 1'b0;
    localparam logic RST_OPM_HALT = 1'b0;
    localparam logic RST_PULSE    = 1'b0;

    function automatic logic cms_is_center(input cms_t cms);
        return cms != CMS_EDGE;
    endfunction

endpackage

// File: rtl/tim1_prescaler.sv
// TIM1 prescaler: preload/shadow pair and divide counter producing the
// counter tick; UG restarts the division.
module tim1_prescaler
    import tim1_pkg::*;
#(
    parameter int unsigned PSC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_ug,
    input  logic             i_load,
    input  logic             i_psc_wr,
    input  logic [PSC_W-1:0] i_psc_data,
    output logic             o_tick
);

    logic [PSC_W-1:0] psc_cnt;
    logic [PSC_W-1:0] psc_shadow;
    logic [PSC_W-1:0] psc_preload;

    assign o_tick = i_en && (psc_cnt == psc_shadow);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psc_cnt     <= '0;
            psc_shadow  <= '0;
            psc_preload <= '0;
        end else begin
            if (i_psc_wr)
                psc_preload <= i_psc_data;
            // Shadow takes the preload as it was before any same-cycle write.
            if (i_load)
                psc_shadow <= psc_preload;
            if (i_ug || o_tick)
                psc_cnt <= '0;
            else if (i_en)
                psc_cnt <= psc_cnt + PSC_W'(1);
        end
    end

endmodule

// File: rtl/tim1_timebase_ctrl.sv
// TIM1 time-base sequencer: counter, ARR preload/shadow, update-event logic.
// Optional repetition counter enabled by defining TIM1_RCR_EN.
module tim1_timebase_ctrl
    import tim1_pkg::*;
#(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned PSC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       i_cr1,
    input  logic             i_psc_wr,
    input  logic [PSC_W-1:0] i_psc_data,
    input  logic             i_arr_wr,
    input  logic [CNT_W-1:0] i_arr_data,
`ifdef TIM1_RCR_EN
    input  logic             i_rcr_wr,
    input  logic [7:0]       i_rcr_data,
`endif
    input  logic             i_ug,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_dir,
    output logic             o_uev,
    output logic             o_uif_set,
    output logic             o_cen_clr,
    output logic [CNT_W-1:0] o_arr_active
);

    logic cen, udis, urs, opm, dir_in, arpe, center;
    cms_t cms;

    assign cen    = i_cr1[CR1_CEN];
    assign udis   = i_cr1[CR1_UDIS];
    assign urs    = i_cr1[CR1_URS];
    assign opm    = i_cr1[CR1_OPM];
    assign dir_in = i_cr1[CR1_DIR];
    assign arpe   = i_cr1[CR1_ARPE];
    assign cms    = cms_t'(i_cr1[CR1_CMS_MSB:CR1_CMS_LSB]);
    assign center = cms_is_center(cms);

    logic [CNT_W-1:0] cnt, cnt_next;
    logic [CNT_W-1:0] arr_preload, arr_active;
    logic             dir_q, dir_next;
    logic             opm_halt;
    logic             uev_q, uif_q, cen_clr_q;
    logic             enable, tick, arr_zero;
    logic             ovf_udf, cnt_evt, uev_now, uif_now, cen_clr_now;

    assign enable   = cen && !opm_halt;
    assign arr_zero = (arr_active == '0);

    tim1_prescaler #(
        .PSC_W (PSC_W)
    ) u_psc (
        .clk        (clk),
        .rst        (rst),
        .i_en       (enable),
        .i_ug       (i_ug),
        .i_load     (uev_now),
        .i_psc_wr   (i_psc_wr),
        .i_psc_data (i_psc_data),
        .o_tick     (tick)
    );

    always_comb begin
        cnt_next = cnt;
        dir_next = center ? dir_q : RST_DIR;
        ovf_udf  = 1'b0;
        if (i_ug) begin
            // UG wins over a same-cycle wrap; edge-down restarts from the reload value.
            dir_next = RST_DIR;
            cnt_next = (!center && dir_in) ? arr_preload : '0;
        end else if (tick && arr_zero) begin
            cnt_next = '0;
        end else if (tick) begin
            if (!center) begin
                if (!dir_in) begin
                    if (cnt == arr_active) begin
                        cnt_next = '0;
                        ovf_udf  = 1'b1;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end else begin
                    if (cnt == '0) begin
                        cnt_next = arr_active;
                        ovf_udf  = 1'b1;
                    end else begin
                        cnt_next = cnt - CNT_W'(1);
                    end
                end
            end else if (!dir_q) begin
                if (cnt == arr_active) begin
                    cnt_next = arr_active - CNT_W'(1);
                    dir_next = 1'b1;
                    ovf_udf  = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end else begin
                if (cnt <= CNT_W'(1)) begin
                    cnt_next = '0;
                    dir_next = 1'b0;
                    ovf_udf  = 1'b1;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
        end
    end

`ifdef TIM1_RCR_EN
    logic [7:0] rep_cnt;
    logic [7:0] rcr_preload;
    logic       rep_zero;

    assign rep_zero = (rep_cnt == '0);
    assign cnt_evt  = ovf_udf && rep_zero && !udis;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_cnt     <= '0;
            rcr_preload <= '0;
        end else begin
            if (i_rcr_wr)
                rcr_preload <= i_rcr_data;
            if (uev_now)
                rep_cnt <= rcr_preload;
            else if (ovf_udf && !rep_zero)
                rep_cnt <= rep_cnt - 8'd1;
        end
    end
`else
    assign cnt_evt = ovf_udf && !udis;
`endif

    assign uev_now     = i_ug || cnt_evt;
    assign uif_now     = i_ug ? !urs : cnt_evt;
    assign cen_clr_now = cnt_evt && opm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            dir_q       <= RST_DIR;
            arr_preload <= '0;
            arr_active  <= '0;
            opm_halt    <= RST_OPM_HALT;
            uev_q       <= RST_PULSE;
            uif_q       <= RST_PULSE;
            cen_clr_q   <= RST_PULSE;
        end else begin
            cnt       <= cnt_next;
            dir_q     <= dir_next;
            uev_q     <= uev_now;
            uif_q     <= uif_now;
            cen_clr_q <= cen_clr_now;
            if (!cen)
                opm_halt <= 1'b0;
            else if (cen_clr_now)
                opm_halt <= 1'b1;
            if (i_arr_wr)
                arr_preload <= i_arr_data;
            if (i_arr_wr && !arpe)
                arr_active <= i_arr_data;
            else if (uev_now && arpe)
                arr_active <= arr_preload;
        end
    end

    assign o_cnt        = cnt;
    assign o_dir        = center ? dir_q : dir_in;
    assign o_uev        = uev_q;
    assign o_uif_set    = uif_q;
    assign o_cen_clr    = cen_clr_q;
    assign o_arr_active = arr_active;

endmodule

// File: tb/tb_tim1_timebase_ctrl.sv
// Self-checking bench for tim1_timebase_ctrl: directed scenarios plus a
// randomized run against a behavioural model (center mode tracked as a phase).
module tb_tim1_timebase_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  i_cr1 = 8'h00;
    logic        i_psc_wr = 1'b0;
    logic [15:0] i_psc_data = 16'd0;
    logic        i_arr_wr = 1'b0;
    logic [15:0] i_arr_data = 16'd0;
    logic        i_ug = 1'b0;
    logic [15:0] o_cnt;
    logic        o_dir;
    logic        o_uev;
    logic        o_uif_set;
    logic        o_cen_clr;
    logic [15:0] o_arr_active;

    int checks = 0;
    int failures = 0;

    // model state
    logic [15:0] m_cnt, m_psc, m_psc_sh, m_psc_pre, m_arr_pre, m_arr_act;
    int          m_phase;
    bit          m_halt;
    bit          e_uev, e_uif, e_cenclr, e_dir;

    always #5 clk = ~clk;

    tim1_timebase_ctrl #(
        .CNT_W (16),
        .PSC_W (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_cr1        (i_cr1),
        .i_psc_wr     (i_psc_wr),
        .i_psc_data   (i_psc_data),
        .i_arr_wr     (i_arr_wr),
        .i_arr_data   (i_arr_data),
`ifdef TIM1_RCR_EN
        .i_rcr_wr     (1'b0),
        .i_rcr_data   (8'd0),
`endif
        .i_ug         (i_ug),
        .o_cnt        (o_cnt),
        .o_dir        (o_dir),
        .o_uev        (o_uev),
        .o_uif_set    (o_uif_set),
        .o_cen_clr    (o_cen_clr),
        .o_arr_active (o_arr_active)
    );

    task automatic model_reset();
        m_cnt = 0; m_psc = 0; m_psc_sh = 0; m_psc_pre = 0;
        m_arr_pre = 0; m_arr_act = 0; m_phase = 0; m_halt = 0;
        e_uev = 0; e_uif = 0; e_cenclr = 0; e_dir = 0;
    endtask

    task automatic model_step();
        bit cen, udis, urs, opm, dirin, arpe, center, en, tk, evt, cevt;
        int period;
        logic [15:0] arr_pre_old;
        cen = i_cr1[0]; udis = i_cr1[1]; urs = i_cr1[2]; opm = i_cr1[3];
        dirin = i_cr1[4]; arpe = i_cr1[7]; center = (i_cr1[6:5] != 2'b00);
        en = cen && !m_halt;
        tk = en && (m_psc == m_psc_sh);
        evt = 0;
        if (i_ug) begin
            m_psc = 0;
            m_phase = 0;
            m_cnt = (!center && dirin) ? m_arr_pre : 16'd0;
        end else begin
            if (tk) m_psc = 0;
            else if (en) m_psc = m_psc + 16'd1;
            if (tk) begin
                if (m_arr_act == 0) begin
                    m_cnt = 0;
                    m_phase = 0;
                end else if (center) begin
                    period = 2 * int'(m_arr_act);
                    evt = (m_phase == int'(m_arr_act)) || (m_phase == period - 1);
                    m_phase = (m_phase + 1) % period;
                    m_cnt = 16'((m_phase <= int'(m_arr_act)) ? m_phase : period - m_phase);
                end else if (!dirin) begin
                    evt = (m_cnt == m_arr_act);
                    m_cnt = evt ? 16'd0 : m_cnt + 16'd1;
                end else begin
                    evt = (m_cnt == 0);
                    m_cnt = evt ? m_arr_act : m_cnt - 16'd1;
                end
            end
        end
        cevt = evt && !udis;
        e_uev = i_ug || cevt;
        e_uif = i_ug ? !urs : cevt;
        e_cenclr = cevt && opm;
        if (!cen) m_halt = 0;
        else if (e_cenclr) m_halt = 1;
        if (e_uev) m_psc_sh = m_psc_pre;
        if (i_psc_wr) m_psc_pre = i_psc_data;
        arr_pre_old = m_arr_pre;
        if (i_arr_wr && !arpe) m_arr_act = i_arr_data;
        else if (e_uev && arpe) m_arr_act = arr_pre_old;
        if (i_arr_wr) m_arr_pre = i_arr_data;
        e_dir = center ? (m_phase > int'(m_arr_act)) : dirin;
    endtask

    task automatic do_cycle();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        #1;
    endtask

    task automatic apply_reset();
        i_cr1 = 0; i_psc_wr = 0; i_arr_wr = 0; i_ug = 0;
        rst = 1;
        do_cycle();
        rst = 0;
    endtask

    task automatic write_arr(input logic [15:0] v);
        i_arr_wr = 1; i_arr_data = v;
        do_cycle();
        i_arr_wr = 0;
    endtask

    task automatic test_reset();
        i_cr1 = 0; i_psc_wr = 0; i_arr_wr = 0; i_ug = 0;
        rst = 1;
        #2;
        checks++; if (o_cnt !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", o_cnt); end
        checks++; if (o_dir !== 1'b0) begin failures++; $display("FAIL reset_dir got=%0b exp=0", o_dir); end
        checks++; if (o_uev !== 1'b0) begin failures++; $display("FAIL reset_uev got=%0b exp=0", o_uev); end
        checks++; if (o_uif_set !== 1'b0) begin failures++; $display("FAIL reset_uif got=%0b exp=0", o_uif_set); end
        checks++; if (o_cen_clr !== 1'b0) begin failures++; $display("FAIL reset_cenclr got=%0b exp=0", o_cen_clr); end
        checks++; if (o_arr_active !== 16'd0) begin failures++; $display("FAIL reset_arr got=%0d exp=0", o_arr_active); end
        do_cycle();
        rst = 0;
    endtask

    task automatic test_edge_up();
        apply_reset();
        write_arr(16'd4);
        i_cr1 = 8'h01;
        for (int k = 1; k <= 10; k++) begin
            do_cycle();
            checks++; if (o_cnt !== 16'(k % 5)) begin failures++; $display("FAIL edge_up_cnt k=%0d got=%0d exp=%0d", k, o_cnt, k % 5); end
            checks++; if (o_uev !== (k % 5 == 0)) begin failures++; $display("FAIL edge_up_uev k=%0d got=%0b exp=%0b", k, o_uev, k % 5 == 0); end
            checks++; if (o_uif_set !== (k % 5 == 0)) begin failures++; $display("FAIL edge_up_uif k=%0d got=%0b exp=%0b", k, o_uif_set, k % 5 == 0); end
        end
    endtask

    task automatic test_psc_change();
        int exp_cnt[11] = '{1, 2, 3, 4, 0, 0, 0, 1, 1, 1, 2};
        apply_reset();
        write_arr(16'd4);
        i_cr1 = 8'h01;
        for (int k = 1; k <= 11; k++) begin
            if (k == 3) begin i_psc_wr = 1; i_psc_data = 16'd2; end
            do_cycle();
            i_psc_wr = 0;
            checks++; if (o_cnt !== 16'(exp_cnt[k-1])) begin failures++; $display("FAIL psc_cnt k=%0d got=%0d exp=%0d", k, o_cnt, exp_cnt[k-1]); end
            checks++; if (o_uev !== (k == 5)) begin failures++; $display("FAIL psc_uev k=%0d got=%0b exp=%0b", k, o_uev, k == 5); end
        end
    endtask

    task automatic test_arpe();
        int e;
        apply_reset();
        write_arr(16'd4);
        i_cr1 = 8'h81;
        for (int k = 1; k <= 15; k++) begin
            if (k == 1) begin i_arr_wr = 1; i_arr_data = 16'd9; end
            do_cycle();
            i_arr_wr = 0;
            e = (k <= 5) ? k % 5 : (k - 5) % 10;
            checks++; if (o_cnt !== 16'(e)) begin failures++; $display("FAIL arpe1_cnt k=%0d got=%0d exp=%0d", k, o_cnt, e); end
            checks++; if (o_uev !== (k == 5 || k == 15)) begin failures++; $display("FAIL arpe1_uev k=%0d got=%0b", k, o_uev); end
            if (k == 1) begin
                checks++; if (o_arr_active !== 16'd4) begin failures++; $display("FAIL arpe1_arr_hold got=%0d exp=4", o_arr_active); end
            end
            if (k == 5) begin
                checks++; if (o_arr_active !== 16'd9) begin failures++; $display("FAIL arpe1_arr_load got=%0d exp=9", o_arr_active); end
            end
        end
        apply_reset();
        write_arr(16'd4);
        i_cr1 = 8'h01;
        for (int k = 1; k <= 10; k++) begin
            if (k == 1) begin i_arr_wr = 1; i_arr_data = 16'd9; end
            do_cycle();
            i_arr_wr = 0;
            checks++; if (o_cnt !== 16'(k % 10)) begin failures++; $display("FAIL arpe0_cnt k=%0d got=%0d exp=%0d", k, o_cnt, k % 10); end
            checks++; if (o_uev !== (k == 10)) begin failures++; $display("FAIL arpe0_uev k=%0d got=%0b", k, o_uev); end
            if (k == 1) begin
                checks++; if (o_arr_active !== 16'd9) begin failures++; $display("FAIL arpe0_arr got=%0d exp=9", o_arr_active); end
            end
        end
    endtask

    task automatic test_center();
        int  ec[8] = '{1, 2, 3, 2, 1, 0, 1, 2};
        bit  ed[8] = '{0, 0, 0, 1, 1, 0, 0, 0};
        bit  eu[8] = '{0, 0, 0, 1, 0, 1, 0, 0};
        apply_reset();
        write_arr(16'd3);
        i_cr1 = 8'h21;
        for (int k = 0; k < 8; k++) begin
            do_cycle();
            checks++; if (o_cnt !== 16'(ec[k])) begin failures++; $display("FAIL center_cnt k=%0d got=%0d exp=%0d", k, o_cnt, ec[k]); end
            checks++; if (o_dir !== ed[k]) begin failures++; $display("FAIL center_dir k=%0d got=%0b exp=%0b", k, o_dir, ed[k]); end
            checks++; if (o_uev !== eu[k]) begin failures++; $display("FAIL center_uev k=%0d got=%0b exp=%0b", k, o_uev, eu[k]); end
        end
    endtask

    task automatic test_ug_urs_udis();
        apply_reset();
        write_arr(16'd4);
        i_cr1 = 8'h05;
        do_cycle(); do_cycle();
        i_ug = 1; do_cycle(); i_ug = 0;
        checks++; if (o_cnt !== 16'd0) begin failures++; $display("FAIL ug_cnt got=%0d exp=0", o_cnt); end
        checks++; if (o_uev !== 1'b1) begin failures++; $display("FAIL ug_uev got=%0b exp=1", o_uev); end
        checks++; if (o_uif_set !== 1'b0) begin failures++; $display("FAIL ug_urs_uif got=%0b exp=0", o_uif_set); end
        do_cycle();
        checks++; if (o_cnt !== 16'd1) begin failures++; $display("FAIL ug_after_cnt got=%0d exp=1", o_cnt); end
        do_cycle(); do_cycle(); do_cycle();
        i_ug = 1; do_cycle(); i_ug = 0;
        checks++; if (o_cnt !== 16'd0) begin failures++; $display("FAIL ug_ovf_cnt got=%0d exp=0", o_cnt); end
        checks++; if (o_uev !== 1'b1) begin failures++; $display("FAIL ug_ovf_uev got=%0b exp=1", o_uev); end
        checks++; if (o_uif_set !== 1'b0) begin failures++; $display("FAIL ug_ovf_uif got=%0b exp=0", o_uif_set); end
        i_cr1 = 8'h03;
        for (int k = 1; k <= 5; k++) begin
            do_cycle();
            checks++; if (o_uev !== 1'b0) begin failures++; $display("FAIL udis_uev k=%0d got=%0b exp=0", k, o_uev); end
            checks++; if (o_cnt !== 16'(k % 5)) begin failures++; $display("FAIL udis_cnt k=%0d got=%0d exp=%0d", k, o_cnt, k % 5); end
        end
        i_ug = 1; do_cycle(); i_ug = 0;
        checks++; if (o_uev !== 1'b1) begin failures++; $display("FAIL udis_ug_uev got=%0b exp=1", o_uev); end
        checks++; if (o_uif_set !== 1'b1) begin failures++; $display("FAIL udis_ug_uif got=%0b exp=1", o_uif_set); end
        i_cr1 = 8'h11;
        i_ug = 1; do_cycle(); i_ug = 0;
        checks++; if (o_cnt !== 16'd4) begin failures++; $display("FAIL ug_down_cnt got=%0d exp=4", o_cnt); end
        checks++; if (o_dir !== 1'b1) begin failures++; $display("FAIL ug_down_dir got=%0b exp=1", o_dir); end
        do_cycle();
        checks++; if (o_cnt !== 16'd3) begin failures++; $display("FAIL down_cnt got=%0d exp=3", o_cnt); end
    endtask

    task automatic test_opm();
        apply_reset();
        write_arr(16'd2);
        i_cr1 = 8'h09;
        for (int k = 1; k <= 8; k++) begin
            do_cycle();
            checks++; if (o_cnt !== 16'((k <= 2) ? k : 0)) begin failures++; $display("FAIL opm_cnt k=%0d got=%0d", k, o_cnt); end
            checks++; if (o_cen_clr !== (k == 3)) begin failures++; $display("FAIL opm_cenclr k=%0d got=%0b exp=%0b", k, o_cen_clr, k == 3); end
            checks++; if (o_uev !== (k == 3)) begin failures++; $display("FAIL opm_uev k=%0d got=%0b exp=%0b", k, o_uev, k == 3); end
        end
        i_cr1 = 8'h08; do_cycle();
        i_cr1 = 8'h09; do_cycle();
        checks++; if (o_cnt !== 16'd1) begin failures++; $display("FAIL opm_restart_cnt got=%0d exp=1", o_cnt); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        write_arr(16'd5);
        i_cr1 = 8'h01;
        do_cycle(); do_cycle(); do_cycle();
        i_cr1 = 8'h81; i_arr_wr = 1; i_arr_data = 16'd7;
        do_cycle();
        i_arr_wr = 0; i_cr1 = 8'h00;
        #2 rst = 1;
        #1;
        checks++; if (o_cnt !== 16'd0) begin failures++; $display("FAIL arst_cnt got=%0d exp=0", o_cnt); end
        checks++; if (o_arr_active !== 16'd0) begin failures++; $display("FAIL arst_arr got=%0d exp=0", o_arr_active); end
        checks++; if (o_uev !== 1'b0 || o_uif_set !== 1'b0 || o_cen_clr !== 1'b0 || o_dir !== 1'b0) begin
            failures++; $display("FAIL arst_pulses got=%0b%0b%0b%0b exp=0000", o_uev, o_uif_set, o_cen_clr, o_dir);
        end
        model_reset();
        do_cycle();
        rst = 0;
        i_cr1 = 8'h01;
        for (int k = 1; k <= 6; k++) begin
            do_cycle();
            checks++; if (o_cnt !== 16'd0 || o_uev !== 1'b0) begin failures++; $display("FAIL arr0_block k=%0d got cnt=%0d uev=%0b exp 0/0", k, o_cnt, o_uev); end
            checks++; if (o_arr_active !== 16'd0) begin failures++; $display("FAIL arr0_active k=%0d got=%0d exp=0", k, o_arr_active); end
        end
        i_ug = 1; do_cycle(); i_ug = 0;
        checks++; if (o_uev !== 1'b1) begin failures++; $display("FAIL arr0_ug_uev got=%0b exp=1", o_uev); end
    endtask

    task automatic test_random();
        logic [7:0] ctl;
        logic [1:0] cms;
        int cen_off;
        cen_off = 0;
        cms = 2'b01;
        apply_reset();
        write_arr(16'd5);
        for (int seg = 0; seg < 2; seg++) begin
            if (seg == 1) begin
                i_cr1 = 8'h00;
                cen_off = 0;
                cms = 2'($urandom_range(3, 1));
                write_arr(16'($urandom_range(6, 2)));
            end
            for (int c = 0; c < 500; c++) begin
                if (c % 50 == 0) begin
                    ctl = 8'($urandom);
                    i_cr1[1] = ctl[1] & ctl[5];
                    i_cr1[2] = ctl[2];
                    i_cr1[3] = ctl[3] & ctl[6];
                    i_cr1[4] = ctl[4];
                    i_cr1[6:5] = (seg == 1) ? cms : 2'b00;
                    i_cr1[7] = (seg == 1) ? 1'b0 : ctl[7];
                    i_ug = 1;
                end else begin
                    i_ug = ($urandom_range(24, 0) == 0);
                end
                i_cr1[0] = (cen_off == 0);
                if (cen_off > 0) cen_off--;
                i_psc_wr = ($urandom_range(7, 0) == 0);
                i_psc_data = 16'($urandom_range(2, 0));
                i_arr_wr = (seg == 0) && i_cr1[7] && ($urandom_range(7, 0) == 0);
                i_arr_data = 16'($urandom_range(7, 1));
                do_cycle();
                checks++; if (o_cnt !== m_cnt) begin failures++; $display("FAIL rand_cnt seg=%0d c=%0d got=%0d exp=%0d", seg, c, o_cnt, m_cnt); end
                checks++; if (o_dir !== e_dir) begin failures++; $display("FAIL rand_dir seg=%0d c=%0d got=%0b exp=%0b", seg, c, o_dir, e_dir); end
                checks++; if (o_uev !== e_uev) begin failures++; $display("FAIL rand_uev seg=%0d c=%0d got=%0b exp=%0b", seg, c, o_uev, e_uev); end
                checks++; if (o_uif_set !== e_uif) begin failures++; $display("FAIL rand_uif seg=%0d c=%0d got=%0b exp=%0b", seg, c, o_uif_set, e_uif); end
                checks++; if (o_cen_clr !== e_cenclr) begin failures++; $display("FAIL rand_cenclr seg=%0d c=%0d got=%0b exp=%0b", seg, c, o_cen_clr, e_cenclr); end
                checks++; if (o_arr_active !== m_arr_act) begin failures++; $display("FAIL rand_arr seg=%0d c=%0d got=%0d exp=%0d", seg, c, o_arr_active, m_arr_act); end
                if (e_cenclr) cen_off = 2;
            end
        end
        i_cr1 = 0; i_ug = 0; i_psc_wr = 0; i_arr_wr = 0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_edge_up();
        test_psc_change();
        test_arpe();
        test_center();
        test_ug_urs_udis();
        test_opm();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tim1_timebase_ctrl.md
Name: tim1_timebase_ctrl

Overview:
Time-base sequencer for TIM1. It consumes the latched 8-bit CR1 word (CEN, UDIS, URS, OPM, DIR, CMS, ARPE) and drives the prescaler, the main counter, auto-reload preload/shadow handling and update-event generation. Its outputs feed the TIM1 status (UIF) and capture/compare blocks, and it requests a CEN clear from the CR1 holder in one-pulse mode.

Parameters:
CNT_W, 16, width of counter and auto-reload register
PSC_W, 16, width of prescaler and prescaler counter

Ports:
clk  in  1  timer kernel clock
rst  in  1  reset; asynchronous, active-high
i_cr1  in  8  CR1 word: [0]CEN [1]UDIS [2]URS [3]OPM [4]DIR [6:5]CMS [7]ARPE
i_psc_wr  in  1  single-cycle write strobe for the prescaler preload
i_psc_data  in  PSC_W  prescaler preload value
i_arr_wr  in  1  single-cycle write strobe for the auto-reload preload
i_arr_data  in  CNT_W  auto-reload value
i_ug  in  1  software update generation, 1-cycle pulse
o_cnt  out  CNT_W  current counter value
o_dir  out  1  actual count direction (1 = down)
o_uev  out  1  update event pulse, 1 cycle
o_uif_set  out  1  sets UIF in the status register, 1 cycle
o_cen_clr  out  1  one-pulse-mode request to clear CR1.CEN, 1 cycle
o_arr_active  out  CNT_W  active (shadow) auto-reload value

Behaviour:
- Reset: cnt=0, psc_cnt=0, psc_shadow=0, psc_preload=0, arr_preload=0, arr_active=0, dir=0, opm_halt=0, all pulse outputs 0.
- Prescaler: psc_cnt counts 0..psc_shadow and produces a tick when psc_cnt==psc_shadow, then wraps to 0. A psc_shadow of 0 gives a tick every enabled cycle. A psc write only updates psc_preload; psc_shadow loads on UEV.
- ARR: with ARPE=1, a write goes to arr_preload and arr_active loads on UEV. With ARPE=0, a write updates arr_preload and arr_active on the next edge.
- Enable: counter and prescaler advance only when CEN=1 and opm_halt=0. When CEN falls, opm_halt clears and cnt holds its value.
- Edge-aligned (CMS=00):
  - Up (DIR=0): on tick, if cnt==arr_active then cnt becomes 0 (overflow); otherwise cnt+1.
  - Down (DIR=1): on tick, if cnt==0 then cnt becomes arr_active (underflow); otherwise cnt-1.
  - o_dir follows DIR.
- Center-aligned (CMS!=00):
  - DIR input is ignored; internal dir toggles.
  - Counting up, on reaching arr_active the next tick counts down (overflow at cnt==arr_active).
  - Counting down, at cnt==1 the tick gives cnt=0 with underflow, and dir becomes up.
  - Switching CMS while CEN=1 is undefined; the bench does not exercise it.
- ARR=0: counter blocked at 0, no overflow/underflow events. UG still works.
- UEV, registered so o_uev appears 1 cycle after the causing tick edge:
  - Raised on overflow/underflow when UDIS=0, or on UG regardless of UDIS.
  - On UEV: psc_shadow<=psc_preload, arr_active<=arr_preload if ARPE=1.
- UG: psc_cnt=0, and cnt=0 (or arr_preload-based ARR when edge-down). In center mode dir becomes up.
- UIF: o_uif_set pulses with o_uev. When URS=1 it does not pulse for a UG-caused UEV.
- Simultaneous UG and overflow in the same cycle: UG takes precedence. One o_uev is issued, and o_uif_set follows the URS rule for UG.
- OPM=1: a counter-caused UEV sets opm_halt and pulses o_cen_clr in the same cycle as o_uev.
- Reset mid-count: everything returns to reset values immediately, including pending preloads.

Optional Feature:
TIM1_RCR_EN
- With the macro: adds ports i_rcr_wr (1) and i_rcr_data (8) and an 8-bit repetition counter.
  - A counter-caused UEV is only issued when rep_cnt==0; otherwise rep_cnt decrements.
  - rep_cnt reloads from the RCR preload on every UEV and on UG.
  - OPM halts on the issued UEV only.
- Without the macro: every overflow/underflow is a UEV candidate, and the ports are absent.

Decomposition:
- Shared package tim1_pkg:
  - CR1 bit-index localparams (CEN..ARPE, CMS msb/lsb).
  - CMS encodings (EDGE=2'b00, CENTER1..3).
  - Reset-value constants.
- One natural sub-module: tim1_prescaler (psc_cnt, preload/shadow, tick output, UG clear).

Test Plan:
- Edge up, PSC=0, ARR=4, CEN=1 -> cnt 0,1,2,3,4,0, o_uev and o_uif_set pulse once per 5 ticks, 1 cycle after wrap.
- PSC write 2 mid-count -> tick period stays 1 until next UEV, then 3 cycles per count.
- ARPE=1, write ARR=9 while ARR=4 -> wraps at 4 once more, then at 9. With ARPE=0 the next wrap is at 9 immediately.
- Center mode CMS=01, ARR=3 -> cnt 0,1,2,3,2,1,0,1; o_dir 0→1 after 3, 1→0 after 0; uev at 3 and 0.
- URS=1 plus UG pulse -> o_uev=1, o_uif_set=0, cnt=0. UDIS=1 with overflow -> no uev.
- OPM=1, ARR=2 -> single overflow, o_cen_clr pulses with uev, cnt frozen at 0 until CEN toggles. Assert rst mid-count -> all outputs 0 asynchronously.
